smc777_kbd: RTL and testbench
=============================

Name: smc777_kbd

Overview:
- Keyboard front-end for the SMC-777 core; sits between hps_io's `ps2_key` output and the core's Z80 keyboard I/O port.
- Detects new PS/2 set-2 events and tracks Shift/Ctrl/Caps state.
- Translates make codes to SMC-777 ASCII through a registered lookup ROM.
- Buffers characters in a first-word-fall-through FIFO that the CPU pops with a read strobe.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  system clock (clk_sys domain).
- reset_n  in  1  asynchronous active-low reset.
- ps2_key  in  11  [10] toggle, [9] pressed, [8] extended, [7:0] scan code.
- rd  in  1  one-clock pop strobe from the CPU port decoder.
- data_out  out  8  FIFO head character.
- key_avail  out  1  FIFO non-empty.
- kbd_status  out  8  {overflow, caps, ctrl, shift, 3'b000, key_avail}.
- status_rd  in  1  one-clock strobe; clears overflow.
- irq  out  1  present only with SMC777_KBD_IRQ_EN, else absent.

Behaviour:
- Reset values:
  - data_out=0, key_avail=0, kbd_status=0, irq=0.
  - FIFO empty; shift/ctrl/caps/overflow=0.
  - last_toggle register loads ps2_key[10] on the first clock after reset release, so no spurious event is generated.
- FSM states and transitions:
  - IDLE: if ps2_key[10]!=last_toggle, latch ps2_key and update last_toggle, then go to DECODE.
  - DECODE: modifier codes update state and return to IDLE:
    - 0x12 / 0x59 (not extended) → shift = pressed.
    - 0x14 (either) → ctrl = pressed.
    - 0x58 press → caps toggles.
  - DECODE, other codes:
    - Break events return to IDLE.
    - Make events present ROM address {ext, code} and go to LOOKUP.
  - LOOKUP: ROM data is valid one clock after the address, then go to PUSH.
  - PUSH: form the character, then go to IDLE.
    - c = shift ? rom_shift : rom_norm.
    - If caps and c is in A–Z/a–z, invert bit 5.
    - If ctrl and c is in 0x40–0x7F, c = c & 0x1F.
    - If c==0 (unmapped), drop it.
    - Otherwise write c to the FIFO.
- Latency:
  - Toggle change visible at clock k → key_avail high at k+4 on an empty FIFO.
  - data_out is valid in the same cycle as key_avail.
- Event spacing: toggle changes arriving while not in IDLE are caught on return to IDLE, because hps_io holds ps2_key stable. Two toggles within 4 clocks collapse to one event (documented limitation).
- FIFO:
  - Write and read pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
  - data_out always shows mem[rd_ptr] (registered, FWFT); it holds its last value when empty.
  - rd while empty: ignored.
  - Push while full with no rd: character dropped, overflow set (sticky).
  - Push and rd in the same clock when full: both take effect, count unchanged, no overflow.
  - Push and rd in the same clock when empty: the push wins and the rd is ignored.
- Overflow clear:
  - status_rd clears overflow on the next clock.
  - A simultaneous overflow event takes priority (overflow stays 1).
- Reset asserted mid-operation: FSM to IDLE, FIFO flushed, modifiers cleared, all asynchronously.

Optional Feature:
- Macro: SMC777_KBD_IRQ_EN.
- When defined:
  - Adds port irq, registered, equal to key_avail delayed one clock.
  - Deasserts in the clock after the rd that empties the FIFO.
- When undefined: irq port and its register are absent; the CPU polls kbd_status[0].

Decomposition:
- Package smc777_kbd_pkg holds:
  - the FSM state enum (IDLE, DECODE, LOOKUP, PUSH);
  - scan-code constants SC_LSHIFT=8'h12, SC_RSHIFT=8'h59, SC_CTRL=8'h14, SC_CAPS=8'h58;
  - the status bit index constants.
- Sub-module smc777_kbd_map: 512-entry × 16-bit synchronous ROM {rom_shift, rom_norm}, initialised from smc777_kbd_map.mif.
- The FIFO stays inline in smc777_kbd.

Test Plan:
- 'A' press, no modifiers: ps2_key={~t,1'b1,1'b0,8'h1C} → key_avail rises 4 clocks later, data_out=8'h61; rd → key_avail=0.
- Shift-A: 0x12 make, then 0x1C make → data_out=8'h41; 0x12 break, then 0x1C make → 8'h61; break codes push nothing.
- Ctrl-C: 0x14 make, then 0x21 make → data_out=8'h03. Caps toggle, then 0x1C → 8'h41; Caps+Shift+0x1C → 8'h61.
- Overflow, FIFO_DEPTH=16:
  - 17 'A' makes with no rd → count 16, kbd_status[7]=1.
  - status_rd → kbd_status[7]=0.
  - Push and rd in the same clock while full → count stays 16, overflow stays 0.
- Reset mid-operation: assert reset_n=0 in LOOKUP with 3 entries queued → key_avail=0 immediately and shift/caps=0. After release, ps2_key unchanged → no event generated.
- SMC777_KBD_IRQ_EN build: one keypress → irq high 1 clock after key_avail; rd → irq low the following clock. Non-IRQ build compiles without the irq port.

Source files
------------

// File: rtl/smc777_kbd_pkg.sv
// Shared types and constants for the SMC-777 keyboard front-end: FSM states,
// PS/2 set-2 modifier scan codes, kbd_status bit positions, character shaping.
package smc777_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    LOOKUP = 2'd2,
    PUSH   = 2'd3
  } kbd_state_e;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam int ST_AVAIL = 0;
  localparam int ST_SHIFT = 4;
  localparam int ST_CTRL  = 5;
  localparam int ST_CAPS  = 6;
  localparam int ST_OVF   = 7;

  function automatic logic is_alpha(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

  // Applies shift selection, then caps case-swap, then ctrl folding; 0 means unmapped.
  function automatic logic [7:0] form_char(input logic [15:0] rom, input logic shift,
                                           input logic caps, input logic ctrl);
    logic [7:0] c;
    c = shift ? rom[15:8] : rom[7:0];
    if (caps && is_alpha(c)) c[5] = ~c[5];
    if (ctrl && (c[7:6] == 2'b01)) c = c & 8'h1F;
    return c;
  endfunction

endpackage

// File: rtl/smc777_kbd_map.sv
// Registered 512 x 16 scan-code ROM {rom_shift, rom_norm} addressed by {ext, code};
// the table is the smc777_kbd_map.mif content written as a case ROM.
module smc777_kbd_map (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [8:0]  addr_i,
  output logic [15:0] data_o
);

  logic [15:0] data_q;

  function automatic logic [15:0] rom_entry(input logic [8:0] a);
    logic [15:0] e;
    e = 16'h0000;
    case (a)
      9'h01C: e = 16'h4161;  9'h032: e = 16'h4262;  9'h021: e = 16'h4363;
      9'h023: e = 16'h4464;  9'h024: e = 16'h4565;  9'h02B: e = 16'h4666;
      9'h034: e = 16'h4767;  9'h033: e = 16'h4868;  9'h043: e = 16'h4969;
      9'h03B: e = 16'h4A6A;  9'h042: e = 16'h4B6B;  9'h04B: e = 16'h4C6C;
      9'h03A: e = 16'h4D6D;  9'h031: e = 16'h4E6E;  9'h044: e = 16'h4F6F;
      9'h04D: e = 16'h5070;  9'h015: e = 16'h5171;  9'h02D: e = 16'h5272;
      9'h01B: e = 16'h5373;  9'h02C: e = 16'h5474;  9'h03C: e = 16'h5575;
      9'h02A: e = 16'h5676;  9'h01D: e = 16'h5777;  9'h022: e = 16'h5878;
      9'h035: e = 16'h5979;  9'h01A: e = 16'h5A7A;
      9'h016: e = 16'h2131;  9'h01E: e = 16'h4032;  9'h026: e = 16'h2333;
      9'h025: e = 16'h2434;  9'h02E: e = 16'h2535;  9'h036: e = 16'h5E36;
      9'h03D: e = 16'h2637;  9'h03E: e = 16'h2A38;  9'h046: e = 16'h2839;
      9'h045: e = 16'h2930;
      9'h04E: e = 16'h5F2D;  9'h055: e = 16'h2B3D;  9'h029: e = 16'h2020;
      9'h05A: e = 16'h0D0D;  9'h066: e = 16'h0808;  9'h076: e = 16'h1B1B;
      9'h00D: e = 16'h0909;  9'h041: e = 16'h3C2C;  9'h049: e = 16'h3E2E;
      9'h04A: e = 16'h3F2F;  9'h04C: e = 16'h3A3B;  9'h052: e = 16'h2227;
      9'h054: e = 16'h7B5B;  9'h05B: e = 16'h7D5D;  9'h05D: e = 16'h7C5C;
      9'h00E: e = 16'h7E60;
      // Extended (E0-prefixed) keys: keypad enter, cursor block, delete.
      9'h15A: e = 16'h0D0D;  9'h175: e = 16'h1E1E;  9'h172: e = 16'h1F1F;
      9'h16B: e = 16'h1D1D;  9'h174: e = 16'h1C1C;  9'h171: e = 16'h7F7F;
      default: e = 16'h0000;
    endcase
    return e;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_q <= 16'h0000;
    else          data_q <= rom_entry(addr_i);
  end

  assign data_o = data_q;

endmodule

// File: rtl/smc777_kbd.sv
// SMC-777 keyboard front-end: PS/2 event detect, modifier tracking, ROM translation
// and an FWFT character FIFO. Define SMC777_KBD_IRQ_EN to add the registered irq output.
module smc777_kbd
  import smc777_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        rd,
  input  logic        status_rd,
  output logic [7:0]  data_out,
  output logic        key_avail,
  output logic [7:0]  kbd_status
`ifdef SMC777_KBD_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  kbd_state_e state_q, state_d;
  logic [9:0] key_q, key_d;
  logic       last_tog_q, last_tog_d;
  logic       armed_q;
  logic       shift_q, shift_d, ctrl_q, ctrl_d, caps_q, caps_d, ovf_q, ovf_d;
  logic [15:0] rom_data;
  logic [7:0] push_char;
  logic       push_req;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             full, empty, do_push, do_pop, ovf_evt;

  logic [7:0] key_code;
  logic       key_pressed, key_ext;
  assign key_code    = key_q[7:0];
  assign key_ext     = key_q[8];
  assign key_pressed = key_q[9];

  smc777_kbd_map u_map (
    .clk     (clk),
    .reset_n (reset_n),
    .addr_i  (key_q[8:0]),
    .data_o  (rom_data)
  );

  assign push_char = form_char(rom_data, shift_q, caps_q, ctrl_q);

  // NOTE: every always_comb output is defaulted first so no path leaves a latch.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    last_tog_d = last_tog_q;
    shift_d    = shift_q;
    ctrl_d     = ctrl_q;
    caps_d     = caps_q;
    push_req   = 1'b0;
    case (state_q)
      IDLE: begin
        // The first clock after reset only samples the toggle, so no stale event fires.
        if (!armed_q) begin
          last_tog_d = ps2_key[10];
        end else if (ps2_key[10] != last_tog_q) begin
          last_tog_d = ps2_key[10];
          key_d      = ps2_key[9:0];
          state_d    = DECODE;
        end
      end
      DECODE: begin
        state_d = IDLE;
        if (!key_ext && ((key_code == SC_LSHIFT) || (key_code == SC_RSHIFT))) begin
          shift_d = key_pressed;
        end else if (key_code == SC_CTRL) begin
          ctrl_d = key_pressed;
        end else if (key_code == SC_CAPS) begin
          if (key_pressed) caps_d = ~caps_q;
        end else if (key_pressed) begin
          state_d = LOOKUP;
        end
      end
      LOOKUP: state_d = PUSH;
      PUSH: begin
        state_d  = IDLE;
        push_req = (push_char != 8'h00);
      end
      default: state_d = IDLE;
    endcase
  end

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = rd && !empty;
  assign do_push = push_req && (!full || do_pop);
  assign ovf_evt = push_req && full && !do_pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(do_pop);
    count_d    = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    ovf_d      = ovf_evt ? 1'b1 : (status_rd ? 1'b0 : ovf_q);
    data_out_d = data_out_q;
    // Registered head: the incoming write is bypassed when it lands on the new head slot.
    if (count_d != '0) begin
      if (do_push && (wr_ptr_q == rd_ptr_d)) data_out_d = push_char;
      else                                   data_out_d = mem[rd_ptr_d];
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      key_q      <= '0;
      last_tog_q <= 1'b0;
      armed_q    <= 1'b0;
      shift_q    <= 1'b0;
      ctrl_q     <= 1'b0;
      caps_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      last_tog_q <= last_tog_d;
      armed_q    <= 1'b1;
      shift_q    <= shift_d;
      ctrl_q     <= ctrl_d;
      caps_q     <= caps_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_char;
  end

  assign data_out  = data_out_q;
  assign key_avail = !empty;

  always_comb begin
    kbd_status           = 8'h00;
    kbd_status[ST_AVAIL] = key_avail;
    kbd_status[ST_SHIFT] = shift_q;
    kbd_status[ST_CTRL]  = ctrl_q;
    kbd_status[ST_CAPS]  = caps_q;
    kbd_status[ST_OVF]   = ovf_q;
  end

`ifdef SMC777_KBD_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= key_avail;
  end
  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_smc777_kbd.sv
// Directed self-checking bench for smc777_kbd (default FIFO_DEPTH=16); covers the
// irq output too when built with SMC777_KBD_IRQ_EN.
module tb_smc777_kbd;

  logic        clk;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic        rd;
  logic        status_rd;
  logic [7:0]  data_out;
  logic        key_avail;
  logic [7:0]  kbd_status;
`ifdef SMC777_KBD_IRQ_EN
  logic        irq;
`endif

  int   total;
  int   bad;
  logic tog;

  smc777_kbd dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_key    (ps2_key),
    .rd         (rd),
    .status_rd  (status_rd),
    .data_out   (data_out),
    .key_avail  (key_avail),
    .kbd_status (kbd_status)
`ifdef SMC777_KBD_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Flip the toggle and present a new event just after a rising edge.
  task automatic drive_key(input logic [7:0] code, input logic pressed, input logic ext);
    tog     = ~tog;
    ps2_key = {tog, pressed, ext, code};
  endtask

  task automatic send(input logic [7:0] code, input logic pressed, input logic ext);
    drive_key(code, pressed, ext);
    ticks(4);
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    tog       = 1'b0;
    reset_n   = 1'b0;
    ps2_key   = 11'h000;
    rd        = 1'b0;
    status_rd = 1'b0;
    #2;
    check("rst_data", data_out, 8'h00);
    check("rst_avail", {7'd0, key_avail}, 8'h00);
    check("rst_status", kbd_status, 8'h00);
`ifdef SMC777_KBD_IRQ_EN
    check("rst_irq", {7'd0, irq}, 8'h00);
`endif
    ticks(2);
    @(negedge clk);
    reset_n = 1'b1;
    ticks(2);
    check("idle_after_rst", kbd_status, 8'h00);

    // Plain 'A': latency of 4 edges from the toggle change.
    drive_key(8'h1C, 1'b1, 1'b0);
    ticks(3);
    check("lat_k3_avail", {7'd0, key_avail}, 8'h00);
    tick();
    check("lat_k4_avail", {7'd0, key_avail}, 8'h01);
    check("a_plain", data_out, 8'h61);
`ifdef SMC777_KBD_IRQ_EN
    check("irq_k4", {7'd0, irq}, 8'h00);
    tick();
    check("irq_k5", {7'd0, irq}, 8'h01);
`endif
    pop();
    check("a_pop_avail", {7'd0, key_avail}, 8'h00);
    check("a_pop_hold", data_out, 8'h61);
`ifdef SMC777_KBD_IRQ_EN
    check("irq_after_rd", {7'd0, irq}, 8'h01);
    tick();
    check("irq_cleared", {7'd0, irq}, 8'h00);
`endif

    // Shift handling and break codes.
    send(8'h12, 1'b1, 1'b0);
    check("shift_on", kbd_status, 8'h10);
    send(8'h1C, 1'b1, 1'b0);
    check("shift_a", data_out, 8'h41);
    pop();
    send(8'h12, 1'b0, 1'b0);
    check("shift_off", kbd_status, 8'h00);
    send(8'h1C, 1'b0, 1'b0);
    check("break_nopush", {7'd0, key_avail}, 8'h00);
    send(8'h1C, 1'b1, 1'b0);
    check("a_after_shift", data_out, 8'h61);
    pop();
    send(8'h59, 1'b1, 1'b0);
    send(8'h16, 1'b1, 1'b0);
    check("rshift_1", data_out, 8'h21);
    pop();
    send(8'h59, 1'b0, 1'b0);

    // Ctrl-C.
    send(8'h14, 1'b1, 1'b0);
    check("ctrl_on", kbd_status, 8'h20);
    send(8'h21, 1'b1, 1'b0);
    check("ctrl_c", data_out, 8'h03);
    pop();
    send(8'h14, 1'b0, 1'b0);
    check("ctrl_off", kbd_status, 8'h00);

    // Caps lock, alone and combined with shift.
    send(8'h58, 1'b1, 1'b0);
    send(8'h58, 1'b0, 1'b0);
    check("caps_on", kbd_status, 8'h40);
    send(8'h1C, 1'b1, 1'b0);
    check("caps_a", data_out, 8'h41);
    pop();
    send(8'h12, 1'b1, 1'b0);
    send(8'h1C, 1'b1, 1'b0);
    check("caps_shift_a", data_out, 8'h61);
    pop();
    send(8'h12, 1'b0, 1'b0);
    send(8'h58, 1'b1, 1'b0);
    check("caps_off", kbd_status, 8'h00);

    // Unmapped code is dropped; extended cursor key maps.
    send(8'h07, 1'b1, 1'b0);
    check("unmapped_drop", {7'd0, key_avail}, 8'h00);
    send(8'h75, 1'b1, 1'b1);
    check("ext_up", data_out, 8'h1E);
    pop();

    // FIFO ordering.
    send(8'h1C, 1'b1, 1'b0);
    send(8'h32, 1'b1, 1'b0);
    send(8'h21, 1'b1, 1'b0);
    check("fifo_0", data_out, 8'h61);
    pop();
    check("fifo_1", data_out, 8'h62);
    pop();
    check("fifo_2", data_out, 8'h63);
    pop();
    check("fifo_empty", {7'd0, key_avail}, 8'h00);

    // Fill to 16 then overflow with a 17th make.
    for (int i = 0; i < 16; i++) send(8'h1C, 1'b1, 1'b0);
    check("full_no_ovf", kbd_status, 8'h01);
    send(8'h1C, 1'b1, 1'b0);
    check("ovf_set", kbd_status, 8'h81);
    status_rd = 1'b1;
    tick();
    status_rd = 1'b0;
    check("ovf_clear", kbd_status, 8'h01);

    // Push 'b' and pop in the same clock while full.
    drive_key(8'h32, 1'b1, 1'b0);
    ticks(3);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("full_pushpop", kbd_status, 8'h01);
    for (int i = 0; i < 15; i++) begin
      check("drain_a", data_out, 8'h61);
      pop();
    end
    check("drain_b", data_out, 8'h62);
    check("drain_b_avail", {7'd0, key_avail}, 8'h01);
    pop();
    check("drain_empty", {7'd0, key_avail}, 8'h00);

    // Reset while the FSM is in LOOKUP with three entries queued.
    send(8'h12, 1'b1, 1'b0);
    send(8'h58, 1'b1, 1'b0);
    send(8'h1C, 1'b1, 1'b0);
    send(8'h32, 1'b1, 1'b0);
    send(8'h21, 1'b1, 1'b0);
    check("pre_rst_status", kbd_status, 8'h51);
    drive_key(8'h1C, 1'b1, 1'b0);
    ticks(2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_avail", {7'd0, key_avail}, 8'h00);
    check("mid_rst_status", kbd_status, 8'h00);
    check("mid_rst_data", data_out, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    ticks(6);
    check("post_rst_no_event", {7'd0, key_avail}, 8'h00);
    check("post_rst_status", kbd_status, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
